// File: rtl/led_matrix_pkg.sv
// Shared types and word packing for the LED matrix frame path.
package led_matrix_pkg;

   localparam int FRAME_WORDS = 512;
   localparam int ADR_W       = 9;
   localparam int RGB_W       = 12;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      PREFETCH,
      STREAM
   } state_t;

   // Controller word layout: {7'b0, adr[8:0], 4'b0, rgb[11:0]}.
   function automatic logic [31:0] pack_word(input logic [ADR_W-1:0] adr,
                                             input logic [RGB_W-1:0] rgb);
      return {7'b0, adr, 4'b0, rgb};
   endfunction

endpackage

// File: rtl/led_frame_ram.sv
// Two-bank frame store: one write port, one read port with a registered output.
module led_frame_ram
   import led_matrix_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_we,
   input  logic [ADR_W:0]   i_wa,
   input  logic [RGB_W-1:0] i_wd,
   input  logic             i_re,
   input  logic [ADR_W:0]   i_ra,
   output logic [RGB_W-1:0] o_rq
);

   logic [RGB_W-1:0] r_mem [0:2*FRAME_WORDS-1];
   logic [RGB_W-1:0] r_rq;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_wa] <= i_wd;
   end

   // Only the read register is reset so the loader's output word starts at zero.
   always_ff @(posedge i_clk) begin
      if (i_reset)   r_rq <= '0;
      else if (i_re) r_rq <= r_mem[i_ra];
   end

   assign o_rq = r_rq;

endmodule

// File: rtl/led_frame_loader.sv
// Double-buffered pixel frame loader: host fills the back bank, commit swaps
// banks and streams the new front bank as one contiguous 512-word burst.
module led_frame_loader
   import led_matrix_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [ADR_W-1:0] wr_adr,
   input  logic [RGB_W-1:0] wr_rgb,
   output logic             wr_ready,
   input  logic             commit,
   output logic             busy,
   output logic             pending,
   output logic [31:0]      data_in,
   output logic             data_in_en
);

   state_t           r_state;
   logic [ADR_W:0]   r_clr_cnt;
   logic             r_front_sel;
   logic             r_pending;
   logic             r_en;
   logic [ADR_W-1:0] r_rd_adr;
   logic [ADR_W-1:0] r_out_adr;

   logic             w_we;
   logic             w_re;
   logic             w_last;
   logic [ADR_W:0]   w_wa;
   logic [ADR_W:0]   w_ra;
   logic [RGB_W-1:0] w_wd;
   logic [RGB_W-1:0] w_rq;

   // The last streamed word is on the output; this cycle drains the burst.
   assign w_last = (r_state == STREAM) && (&r_out_adr);

   assign wr_ready = (r_state != CLEAR) && !r_pending;
   assign w_we     = (r_state == CLEAR) || (wr_en && wr_ready);
   assign w_wa     = (r_state == CLEAR) ? r_clr_cnt : {~r_front_sel, wr_adr};
   assign w_wd     = (r_state == CLEAR) ? '0 : wr_rgb;
   assign w_re     = (r_state == PREFETCH) || ((r_state == STREAM) && !w_last);
   assign w_ra     = {r_front_sel, r_rd_adr};

   led_frame_ram u_ram (
      .i_clk   (clk),
      .i_reset (reset),
      .i_we    (w_we),
      .i_wa    (w_wa),
      .i_wd    (w_wd),
      .i_re    (w_re),
      .i_ra    (w_ra),
      .o_rq    (w_rq)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= CLEAR;
         r_clr_cnt   <= '0;
         r_front_sel <= 1'b0;
         r_pending   <= 1'b0;
         r_en        <= 1'b0;
         r_rd_adr    <= '0;
         r_out_adr   <= '0;
      end else begin
         case (r_state)
            CLEAR: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (&r_clr_cnt) begin
                  r_front_sel <= 1'b0;
                  r_state     <= PREFETCH;
               end
            end
            IDLE: begin
               if (commit || r_pending) begin
                  r_front_sel <= ~r_front_sel;
                  r_pending   <= 1'b0;
                  r_state     <= PREFETCH;
               end
            end
            PREFETCH, STREAM: begin
               if (commit) r_pending <= 1'b1;
               if (w_last) begin
                  r_en    <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  // Valid and address register alongside the RAM read data.
                  r_en      <= 1'b1;
                  r_out_adr <= r_rd_adr;
                  r_rd_adr  <= r_rd_adr + 1'b1;
                  r_state   <= STREAM;
               end
            end
            default: r_state <= CLEAR;
         endcase
      end
   end

   assign busy       = (r_state != IDLE);
   assign pending    = r_pending;
   assign data_in_en = r_en;
   assign data_in    = pack_word(r_out_adr, w_rq);

endmodule

// File: tb/tb_led_frame_loader.sv
// Directed bench for led_frame_loader: clear pass, frame streaming, write
// protection, merged commits, reset mid-burst and same-cycle write+commit.
module tb_led_frame_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_en = 1'b0;
   logic [8:0]  wr_adr = '0;
   logic [11:0] wr_rgb = '0;
   logic        commit = 1'b0;
   logic        wr_ready;
   logic        busy;
   logic        pending;
   logic [31:0] data_in;
   logic        data_in_en;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [11:0] exp_rgb [512];

   always #5 clk = ~clk;

   led_frame_loader dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_adr     (wr_adr),
      .wr_rgb     (wr_rgb),
      .wr_ready   (wr_ready),
      .commit     (commit),
      .busy       (busy),
      .pending    (pending),
      .data_in    (data_in),
      .data_in_en (data_in_en)
   );

   function automatic logic [31:0] word(input int a, input logic [11:0] c);
      return {7'd0, 9'(a), 4'd0, c};
   endfunction

   function automatic logic [11:0] pat_a(input int k);
      return {3'b0, 9'(k)} ^ 12'h5A5;
   endfunction

   function automatic logic [11:0] pat_b(input int k);
      return 12'(k * 7) ^ 12'hC3C;
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_exp(input int sel);
      for (int k = 0; k < 512; k++)
         exp_rgb[k] = (sel == 1) ? pat_a(k) : (sel == 2) ? pat_b(k) : 12'h000;
   endtask

   // Called right after reset is released: 1023 CLEAR samples, commit ignored.
   task automatic clear_phase(input string tag);
      int bad;
      bad = 0;
      if (!(busy === 1'b1 && wr_ready === 1'b0 && data_in_en === 1'b0)) bad++;
      for (int i = 0; i < 1023; i++) begin
         tick();
         commit = 1'b0;
         if (!(busy === 1'b1 && wr_ready === 1'b0 && data_in_en === 1'b0)) bad++;
         if (i == 600) commit = 1'b1;
      end
      check({tag, " clear busy/ready"}, 32'(bad), 32'd0);
      check({tag, " clear commit ignored"}, {31'd0, pending}, 32'd0);
   endtask

   // Current sample and `lead` more must be idle, then 512 words, then idle.
   task automatic run_burst(input string tag, input int lead, input bit wr_b,
                            input int c1, input int c2, input int rst_at, input int drop_at);
      int bad;
      bit aborted;
      bad = 0;
      aborted = 1'b0;
      if (data_in_en !== 1'b0) bad++;
      for (int i = 0; i < lead; i++) begin
         tick();
         if (data_in_en !== 1'b0) bad++;
      end
      check({tag, " lead low"}, 32'(bad), 32'd0);
      for (int k = 0; k < 512 && !aborted; k++) begin
         tick();
         commit = 1'b0;
         wr_en  = 1'b0;
         check($sformatf("%s en w%0d", tag, k), {31'd0, data_in_en}, 32'd1);
         check($sformatf("%s word w%0d", tag, k), data_in, word(k, exp_rgb[k]));
         if (c1 >= 0 && k == c1 + 1) begin
            check({tag, " pending set"}, {31'd0, pending}, 32'd1);
            check({tag, " ready dropped"}, {31'd0, wr_ready}, 32'd0);
         end
         if (wr_b) begin
            wr_en  = 1'b1;
            wr_adr = 9'(k);
            wr_rgb = pat_b(k);
         end
         if (k == drop_at) begin
            wr_en  = 1'b1;
            wr_adr = 9'h003;
            wr_rgb = 12'hFFF;
         end
         if (k == c1 || k == c2) commit = 1'b1;
         if (k == rst_at) begin
            reset   = 1'b1;
            aborted = 1'b1;
         end
      end
      tick();
      commit = 1'b0;
      wr_en  = 1'b0;
      check({tag, " trailing low"}, {31'd0, data_in_en}, 32'd0);
   endtask

   task automatic pulse_commit(input bit with_wr, input logic [8:0] a, input logic [11:0] c);
      commit = 1'b1;
      if (with_wr) begin
         wr_en  = 1'b1;
         wr_adr = a;
         wr_rgb = c;
      end
      tick();
      commit = 1'b0;
      wr_en  = 1'b0;
   endtask

   initial begin
      int bad;
      repeat (3) tick();
      check("rst data_in", data_in, 32'd0);
      check("rst data_in_en", {31'd0, data_in_en}, 32'd0);
      check("rst pending", {31'd0, pending}, 32'd0);
      check("rst busy", {31'd0, busy}, 32'd1);
      check("rst wr_ready", {31'd0, wr_ready}, 32'd0);

      // Reset release: clear both banks, then one black frame.
      reset = 1'b0;
      clear_phase("boot");
      set_exp(0);
      run_burst("boot", 1, 1'b0, -1, -1, -1, -1);
      check("boot busy after", {31'd0, busy}, 32'd0);
      check("boot ready idle", {31'd0, wr_ready}, 32'd1);

      // Single frame: fill back bank with pattern A, commit.
      for (int k = 0; k < 512; k++) begin
         wr_en  = 1'b1;
         wr_adr = 9'(k);
         wr_rgb = pat_a(k);
         tick();
      end
      wr_en = 1'b0;
      pulse_commit(1'b0, 9'h0, 12'h0);
      check("frameA prefetch busy", {31'd0, busy}, 32'd1);
      set_exp(1);
      // Pattern B written into the back bank while A streams.
      run_burst("frameA", 0, 1'b1, -1, -1, -1, -1);

      check("frameB idle", {31'd0, busy}, 32'd0);
      pulse_commit(1'b0, 9'h0, 12'h0);
      set_exp(2);
      run_burst("frameB", 0, 1'b0, -1, -1, -1, -1);

      // Two commits during one burst merge into a single extra burst;
      // a write while pending must be dropped.
      pulse_commit(1'b0, 9'h0, 12'h0);
      set_exp(1);
      run_burst("dblA", 0, 1'b0, 100, 300, -1, 150);
      set_exp(2);
      run_burst("dblB", 1, 1'b0, -1, -1, -1, -1);
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (data_in_en !== 1'b0) bad++;
      end
      check("dbl no third burst", 32'(bad), 32'd0);
      check("dbl busy clear", {31'd0, busy}, 32'd0);
      check("dbl pending clear", {31'd0, pending}, 32'd0);
      check("dbl data_in hold", data_in, word(511, pat_b(511)));

      // Same-cycle write+commit lands in the bank about to become front.
      pulse_commit(1'b1, 9'h0FF, 12'hF00);
      set_exp(1);
      exp_rgb[255] = 12'hF00;
      run_burst("wrcommit", 0, 1'b0, -1, -1, -1, -1);

      // Reset at burst word 200, then clear pass and an all-black frame.
      pulse_commit(1'b0, 9'h0, 12'h0);
      set_exp(2);
      run_burst("rstmid", 0, 1'b0, -1, -1, 200, -1);
      check("rstmid pending", {31'd0, pending}, 32'd0);
      check("rstmid busy", {31'd0, busy}, 32'd1);
      check("rstmid data_in", data_in, 32'd0);
      reset = 1'b0;
      clear_phase("rst2");
      set_exp(0);
      run_burst("rst2", 1, 1'b0, -1, -1, -1, -1);
      check("rst2 busy after", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
